// File: rtl/rtc_pps_gen_if.sv
// rtc_pps_gen_if: time inputs, controls and pulse outputs of rtc_pps_gen.
// master drives the RTC time and controls; slave is the pulse generator.
interface rtc_pps_gen_if;
    logic [47:0] time_reg_sec;
    logic [37:0] time_reg_ns;
    logic        pps_en;
    logic        width_ld;
    logic [23:0] pulse_width_in;
    logic        trig_ld;
    logic [47:0] trig_sec_in;
    logic [29:0] trig_ns_in;
    logic        trig_cancel;
    logic        pps_out;
    logic        trig_out;
    logic        trig_armed;
    logic        trig_done;

    modport master (
        output time_reg_sec, time_reg_ns, pps_en,
        output width_ld, pulse_width_in,
        output trig_ld, trig_sec_in, trig_ns_in, trig_cancel,
        input  pps_out, trig_out, trig_armed, trig_done
    );

    modport slave (
        input  time_reg_sec, time_reg_ns, pps_en,
        input  width_ld, pulse_width_in,
        input  trig_ld, trig_sec_in, trig_ns_in, trig_cancel,
        output pps_out, trig_out, trig_armed, trig_done
    );
endinterface

// File: rtl/rtc_pps_gen.sv
// rtc_pps_gen: PPS pulse on natural RTC second rollovers plus a one-shot
// trigger pulse at a programmed target time; widths in clk cycles.
// Ports: clk, rst (async, active-high), pif (rtc_pps_gen_if.slave).
module rtc_pps_gen #(
    parameter logic [23:0] PULSE_WIDTH_RST = 24'd12500000
) (
    input logic          clk,
    input logic          rst,
    rtc_pps_gen_if.slave pif
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRING
    } trig_state_t;

    logic [47:0] sec_d1;
    logic [29:0] ns_d1;
    logic [29:0] ns_now;
    logic        rollover;

    logic [23:0] width_q;
    logic [23:0] width_eff;

    logic [23:0] pps_cnt;
    logic        pps_q;

    logic [47:0] tgt_sec;
    logic [29:0] tgt_ns;
    logic        hit;

    trig_state_t state, state_n;
    logic [23:0] trig_cnt, trig_cnt_n;
    logic        done_n;
    logic        trig_out_q;
    logic        trig_armed_q;
    logic        trig_done_q;

    // the sub-ns fraction plays no part in pulse timing
    logic        unused_frac;
    assign unused_frac = ^pif.time_reg_ns[7:0];

    assign ns_now = pif.time_reg_ns[37:8];

    // A natural rollover is exactly sec+1 with the ns field wrapping.
    // The sum is 48 bits, so all-ones -> 0 counts as a rollover too.
    assign rollover = (pif.time_reg_sec == sec_d1 + 48'd1)
                   && (ns_now < ns_d1);

    assign width_eff = (width_q == 24'd0) ? 24'd1 : width_q;

    assign hit = {pif.time_reg_sec, ns_now} >= {tgt_sec, tgt_ns};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_d1 <= '0;
            ns_d1  <= '0;
        end else begin
            sec_d1 <= pif.time_reg_sec;
            ns_d1  <= ns_now;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q <= PULSE_WIDTH_RST;
        end else if (pif.width_ld) begin
            width_q <= pif.pulse_width_in;
        end
    end

    // pps_out mirrors "counter non-zero after this edge"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pps_cnt <= '0;
            pps_q   <= 1'b0;
        end else if (!pif.pps_en) begin
            pps_cnt <= '0;
            pps_q   <= 1'b0;
        end else if (rollover) begin
            pps_cnt <= width_eff;
            pps_q   <= 1'b1;
        end else if (pps_cnt != 24'd0) begin
            pps_cnt <= pps_cnt - 24'd1;
            pps_q   <= (pps_cnt != 24'd1);
        end
    end

    always_comb begin
        state_n    = state;
        trig_cnt_n = trig_cnt;
        done_n     = 1'b0;
        if (pif.trig_ld) begin
            state_n    = ARMED;
            trig_cnt_n = '0;
        end else if (pif.trig_cancel) begin
            state_n    = IDLE;
            trig_cnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                ARMED: begin
                    if (hit) begin
                        state_n    = FIRING;
                        trig_cnt_n = width_eff;
                    end
                end
                FIRING: begin
                    if (trig_cnt <= 24'd1) begin
                        state_n    = IDLE;
                        trig_cnt_n = '0;
                        done_n     = 1'b1;
                    end else begin
                        trig_cnt_n = trig_cnt - 24'd1;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    trig_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            trig_cnt     <= '0;
            trig_out_q   <= 1'b0;
            trig_armed_q <= 1'b0;
            trig_done_q  <= 1'b0;
            tgt_sec      <= '0;
            tgt_ns       <= '0;
        end else begin
            state        <= state_n;
            trig_cnt     <= trig_cnt_n;
            trig_out_q   <= (state_n == FIRING);
            trig_armed_q <= (state_n == ARMED);
            trig_done_q  <= done_n;
            if (pif.trig_ld) begin
                tgt_sec <= pif.trig_sec_in;
                tgt_ns  <= pif.trig_ns_in;
            end
        end
    end

    assign pif.pps_out    = pps_q;
    assign pif.trig_out   = trig_out_q;
    assign pif.trig_armed = trig_armed_q;
    assign pif.trig_done  = trig_done_q;

endmodule

// File: tb/tb_rtc_pps_gen.sv
// tb_rtc_pps_gen: randomized and directed stimulus against a timestamp-based
// reference model; every output is compared on every cycle.
module tb_rtc_pps_gen;

    localparam logic [23:0] W_RST = 24'd12500000;
    localparam int unsigned NS_MAX = 32'd1000000000;

    logic clk = 1'b0;
    logic rst;
    always #4 clk = ~clk;

    rtc_pps_gen_if pif ();

    rtc_pps_gen #(.PULSE_WIDTH_RST(W_RST)) dut (
        .clk(clk),
        .rst(rst),
        .pif(pif.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [47:0] cur_sec;
    int unsigned cur_ns;

    // reference model state: edge index and pulse end timestamps
    longint      e;
    longint      pps_until;
    longint      fire_until;
    longint      done_edge;
    int          tmode;
    logic [47:0] m_psec;
    logic [29:0] m_pns;
    logic [23:0] m_w;
    logic [47:0] t_sec;
    logic [29:0] t_ns;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h",
                     tag, e, got, exp);
        end
    endtask

    task automatic model_reset();
        e          = 0;
        pps_until  = 0;
        fire_until = 0;
        done_edge  = -1;
        tmode      = 0;
        m_psec     = '0;
        m_pns      = '0;
        m_w        = W_RST;
        t_sec      = '0;
        t_ns       = '0;
    endtask

    task automatic drive_time();
        logic [29:0] ns30;
        logic [7:0]  frac;
        ns30 = cur_ns[29:0];
        frac = 8'($urandom);
        pif.time_reg_sec = cur_sec;
        pif.time_reg_ns  = {ns30, frac};
    endtask

    task automatic set_time(input logic [47:0] s, input int unsigned n);
        cur_sec = s;
        cur_ns  = n;
        drive_time();
    endtask

    task automatic check_outs();
        chk("pps_out", 64'(pif.pps_out), 64'(e < pps_until));
        chk("trig_out", 64'(pif.trig_out), 64'(tmode == 2));
        chk("trig_armed", 64'(pif.trig_armed), 64'(tmode == 1));
        chk("trig_done", 64'(pif.trig_done), 64'(done_edge == e));
    endtask

    // One clock: predict from current inputs, clock, compare, advance time.
    task automatic tick();
        logic [47:0] s;
        logic [29:0] n;
        logic        roll;
        longint      weff;
        logic [77:0] now_t;
        logic [77:0] tgt_t;
        s    = pif.time_reg_sec;
        n    = pif.time_reg_ns[37:8];
        roll = (s == m_psec + 48'd1) && (n < m_pns);
        weff = (m_w == 24'd0) ? 1 : longint'(m_w);
        e++;
        if (!pif.pps_en) pps_until = e;
        else if (roll) pps_until = e + weff;
        if (pif.width_ld) m_w = pif.pulse_width_in;
        now_t = {s, n};
        tgt_t = {t_sec, t_ns};
        if (pif.trig_ld) begin
            tmode = 1;
            t_sec = pif.trig_sec_in;
            t_ns  = pif.trig_ns_in;
        end else if (pif.trig_cancel) begin
            tmode = 0;
        end else if (tmode == 1 && now_t >= tgt_t) begin
            tmode      = 2;
            fire_until = e + weff;
        end else if (tmode == 2 && e == fire_until) begin
            tmode     = 0;
            done_edge = e;
        end
        m_psec = s;
        m_pns  = n;
        @(posedge clk);
        #1;
        check_outs();
        pif.width_ld    = 1'b0;
        pif.trig_ld     = 1'b0;
        pif.trig_cancel = 1'b0;
        cur_ns += 8;
        if (cur_ns >= NS_MAX) begin
            cur_ns -= NS_MAX;
            cur_sec++;
        end
        drive_time();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_width(input logic [23:0] w);
        pif.width_ld       = 1'b1;
        pif.pulse_width_in = w;
        tick();
    endtask

    task automatic arm(input logic [47:0] s, input logic [29:0] n);
        pif.trig_ld     = 1'b1;
        pif.trig_sec_in = s;
        pif.trig_ns_in  = n;
    endtask

    initial begin
        rst                = 1'b1;
        pif.pps_en         = 1'b0;
        pif.width_ld       = 1'b0;
        pif.pulse_width_in = '0;
        pif.trig_ld        = 1'b0;
        pif.trig_sec_in    = '0;
        pif.trig_ns_in     = '0;
        pif.trig_cancel    = 1'b0;
        set_time(48'd0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_outs();
        rst = 1'b0;

        // reset width is used by the first pulse, then cut by pps_en
        pif.pps_en = 1'b1;
        set_time(48'd3, NS_MAX - 16);
        run(8);
        pif.pps_en = 1'b0;
        run(2);
        pif.pps_en = 1'b1;

        // load near the wrap: one 4-cycle pulse, none at the load
        load_width(24'd4);
        set_time(48'd10, 999999900);
        run(24);

        // jump 11 -> 20 is not a rollover; 20 -> 21 is
        set_time(48'd20, 999999960);
        run(12);

        // target 12 s / 500 ns, width 3; step time back first
        load_width(24'd3);
        set_time(48'd12, 400);
        arm(48'd12, 30'd500);
        run(30);

        // target in the past
        arm(48'd5, 30'd0);
        run(8);

        // cancel while armed
        arm(cur_sec + 48'd100, 30'd0);
        run(3);
        pif.trig_cancel = 1'b1;
        run(4);

        // re-arm during FIRING aborts without trig_done
        load_width(24'd8);
        arm(48'd0, 30'd0);
        run(4);
        arm(cur_sec + 48'd50, 30'd0);
        run(3);

        // load and cancel together: load wins
        arm(cur_sec + 48'd60, 30'd7);
        pif.trig_cancel = 1'b1;
        run(2);
        pif.trig_cancel = 1'b1;
        run(2);

        // zero width gives 1-cycle pulses
        load_width(24'd0);
        set_time(48'd30, NS_MAX - 24);
        run(10);

        // second rollover inside a 10-cycle pulse extends it
        load_width(24'd10);
        set_time(48'd40, NS_MAX - 16);
        run(5);
        set_time(cur_sec, 999999000);
        tick();
        set_time(cur_sec + 48'd1, 0);
        run(4);
        pif.pps_en = 1'b0;
        run(3);
        pif.pps_en = 1'b1;

        // 48-bit seconds wrap with ns wrap pulses
        load_width(24'd2);
        set_time(48'hFFFF_FFFF_FFFF, NS_MAX - 16);
        run(8);

        // async reset in the middle of both pulses
        load_width(24'd12);
        set_time(48'd50, NS_MAX - 8);
        arm(48'd0, 30'd0);
        run(4);
        rst = 1'b1;
        #1;
        chk("rst_pps", 64'(pif.pps_out), 64'd0);
        chk("rst_trig", 64'(pif.trig_out), 64'd0);
        chk("rst_armed", 64'(pif.trig_armed), 64'd0);
        chk("rst_done", 64'(pif.trig_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        load_width(24'd5);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                set_time(cur_sec + 48'($urandom_range(0, 2)),
                         NS_MAX - 8 * $urandom_range(1, 40));
            end else if (r < 5) begin
                pif.pps_en = ($urandom_range(0, 3) != 0);
            end else if (r < 7) begin
                pif.width_ld       = 1'b1;
                pif.pulse_width_in = 24'($urandom_range(0, 12));
            end else if (r < 10) begin
                arm(cur_sec + 48'($urandom_range(0, 1)),
                    30'($urandom_range(0, NS_MAX - 1)));
                if ($urandom_range(0, 7) == 0) pif.trig_cancel = 1'b1;
            end else if (r < 11) begin
                pif.trig_cancel = 1'b1;
            end else if (r < 12 && cur_ns > 0) begin
                set_time(cur_sec + 48'd1, 0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
